// File: rtl/conv_pkg.sv
// Shared constants for the conv PIM datapath: pixel width and 3x3 window geometry.
// The core sizes its operand port from OPERANDS_W, so keep these in sync with it.
package conv_pkg;

  localparam int DATA_W     = 12;
  localparam int WIN_K      = 3;
  localparam int WIN_N      = WIN_K * WIN_K;
  localparam int OPERANDS_W = WIN_N * DATA_W;

  // LSB position of lane k (k = row*WIN_K + col) in a packed window of w-bit lanes.
  function automatic int lane_lsb(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// One image row of pixel storage: asynchronous read at addr, write at addr when we is high.
// Contents are never reset; the window generator never emits a location before it is rewritten.
module conv_line_buffer #(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 8,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/conv_window_gen.sv
// Builds stride-1, unpadded 3x3 windows from a raster pixel stream using two line buffers
// and presents each window on a registered valid/ready output.
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int DATA_W = conv_pkg::DATA_W,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [DATA_W-1:0]       in_data,
  output logic                    in_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIN_N*DATA_W-1:0] operands,
  output logic                    frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_MIN  = CW'(WIN_K - 1);
  localparam logic [RW-1:0] ROW_MIN  = RW'(WIN_K - 1);

  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic              accept;
  logic              emit;
  logic              last_px;
  logic [DATA_W-1:0] lb1_rdata;
  logic [DATA_W-1:0] lb2_rdata;

  logic [DATA_W-1:0]       new_col  [WIN_K];
  logic [DATA_W-1:0]       win      [WIN_K][WIN_K];
  logic [DATA_W-1:0]       win_next [WIN_K][WIN_K];
  logic [WIN_N*DATA_W-1:0] ops_next;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign last_px  = (col == COL_LAST) && (row == ROW_LAST);
  // The row gate also blocks windows whose upper rows would come from the previous frame.
  assign emit     = accept && (row >= ROW_MIN) && (col >= COL_MIN);

  conv_line_buffer #(
    .DATA_W (DATA_W),
    .DEPTH  (IMG_W)
  ) u_lb1 (
    .clk   (clk),
    .we    (accept),
    .addr  (col),
    .wdata (in_data),
    .rdata (lb1_rdata)
  );

  conv_line_buffer #(
    .DATA_W (DATA_W),
    .DEPTH  (IMG_W)
  ) u_lb2 (
    .clk   (clk),
    .we    (accept),
    .addr  (col),
    .wdata (lb1_rdata),
    .rdata (lb2_rdata)
  );

  // Row 0 of the incoming column is the oldest line, row 2 the pixel arriving now.
  always_comb begin
    new_col[0] = lb2_rdata;
    new_col[1] = lb1_rdata;
    new_col[2] = in_data;
  end

  always_comb begin
    ops_next = '0;
    for (int r = 0; r < WIN_K; r++) begin
      for (int c = 0; c < WIN_K - 1; c++) begin
        win_next[r][c] = win[r][c+1];
      end
      win_next[r][WIN_K-1] = new_col[r];
    end
    for (int r = 0; r < WIN_K; r++) begin
      for (int c = 0; c < WIN_K; c++) begin
        ops_next[lane_lsb(r*WIN_K + c, DATA_W) +: DATA_W] = win_next[r][c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col <= '0;
      row <= '0;
      for (int r = 0; r < WIN_K; r++) begin
        for (int c = 0; c < WIN_K; c++) begin
          win[r][c] <= '0;
        end
      end
    end else if (accept) begin
      for (int r = 0; r < WIN_K; r++) begin
        for (int c = 0; c < WIN_K; c++) begin
          win[r][c] <= win_next[r][c];
        end
      end
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // An accept implies the held window (if any) is consumed this edge, so it is
  // either replaced by the new window or retired.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      operands   <= '0;
    end else if (accept) begin
      out_valid  <= emit;
      frame_done <= emit && last_px;
      if (emit) operands <= ops_next;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// Scoreboard bench for conv_window_gen: stimulus pushes expected windows, a negedge monitor
// pops and compares each window the DUT hands over.
module tb_conv_window_gen;
  import conv_pkg::*;

  localparam int W  = 8;
  localparam int H  = 8;
  localparam int DW = 12;
  localparam int OW = 9 * DW;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] operands;
  logic          frame_done;

  always #5 clk = ~clk;

  conv_window_gen #(
    .DATA_W (DW),
    .IMG_W  (W),
    .IMG_H  (H)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .operands   (operands),
    .frame_done (frame_done)
  );

  typedef struct packed {
    logic [OW-1:0] ops;
    logic          fd;
  } exp_t;

  exp_t          exp_q [$];
  logic [OW-1:0] seen  [$];
  int n_checks = 0;
  int n_fail   = 0;
  int win_cnt  = 0;
  int fd_cnt   = 0;
  int img [W*H];
  int brow = 0;
  int bcol = 0;
  logic bp_arm = 1'b0;

  int first_a [9] = '{0, 1, 2, 8, 9, 10, 16, 17, 18};
  int last_a  [9] = '{45, 46, 47, 53, 54, 55, 61, 62, 63};
  int first_r [9] = '{100, 101, 102, 108, 109, 110, 116, 117, 118};
  int first_b [9] = '{200, 201, 202, 208, 209, 210, 216, 217, 218};

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [OW-1:0] pack9(input int v [9]);
    logic [OW-1:0] p;
    p = '0;
    for (int k = 0; k < 9; k++) p[k*DW +: DW] = DW'(v[k]);
    return p;
  endfunction

  // Reference model: record the pixel at the bench's own raster position and,
  // if a full 3x3 neighbourhood ends here, queue the window read from the image.
  task automatic model_pixel(input int v);
    exp_t e;
    img[brow*W + bcol] = v;
    if (brow >= 2 && bcol >= 2) begin
      e.ops = '0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          e.ops[(r*3 + c)*DW +: DW] = DW'(img[(brow-2+r)*W + (bcol-2+c)]);
      e.fd = (brow == H-1) && (bcol == W-1);
      exp_q.push_back(e);
    end
    if (bcol == W-1) begin
      bcol = 0;
      brow = (brow == H-1) ? 0 : brow + 1;
    end else begin
      bcol = bcol + 1;
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_window", out_valid, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("window_ops", operands, e.ops);
        check("window_frame_done", frame_done, e.fd);
      end
      seen.push_back(operands);
      win_cnt++;
      if (frame_done) fd_cnt++;
    end
  end

  // Backpressure: hold out_ready low for 5 edges once the first window appears.
  initial begin : bp_proc
    int t;
    out_ready = 1'b1;
    wait (bp_arm);
    t = 0;
    do begin
      @(posedge clk); #1;
      t++;
    end while (!out_valid && t < 2000);
    check("bp_first_window_seen", out_valid, 1'b1);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_k8", operands[8*DW +: DW], 18);
      check("bp_hold_k0", operands[DW-1:0], 0);
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_out_valid", out_valid, 1'b1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
  end

  task automatic send_pixel(input int v);
    int  t;
    bit  done;
    t = 0;
    done = 0;
    in_valid = 1'b1;
    in_data  = DW'(v);
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        model_pixel(v);
        done = 1;
      end else begin
        t++;
        if (t > 100) begin
          check("accept_timeout", in_ready, 1'b1);
          done = 1;
        end
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // sparse=1 gives the in_valid pattern 1,0,0,1 repeating.
  task automatic send_frame(input int base, input bit sparse);
    for (int idx = 0; idx < W*H; idx++) begin
      send_pixel(base + idx);
      if (sparse && (idx % 2 == 0)) idle(2);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
  endtask

  task automatic start_test();
    seen.delete();
    win_cnt = 0;
    fd_cnt  = 0;
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_operands", operands, 0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    // Streaming frame
    start_test();
    send_frame(0, 1'b0);
    drain();
    check("stream_count", win_cnt, 36);
    check("stream_frame_done_count", fd_cnt, 1);
    if (seen.size() >= 36) begin
      check("stream_first_window", seen[0], pack9(first_a));
      check("stream_last_window", seen[35], pack9(last_a));
    end

    // Backpressure
    start_test();
    bp_arm = 1'b1;
    send_frame(0, 1'b0);
    drain();
    check("bp_count", win_cnt, 36);
    if (seen.size() >= 2) begin
      check("bp_window0_k8", seen[0][8*DW +: DW], 18);
      check("bp_window1_k8", seen[1][8*DW +: DW], 19);
    end

    // Sparse input
    start_test();
    send_frame(0, 1'b1);
    drain();
    check("sparse_count", win_cnt, 36);
    check("sparse_frame_done_count", fd_cnt, 1);
    if (seen.size() >= 36) begin
      check("sparse_first_window", seen[0], pack9(first_a));
      check("sparse_last_window", seen[35], pack9(last_a));
    end

    // Reset mid-frame: the window produced by the 30th accept is left pending and discarded.
    start_test();
    for (int idx = 0; idx < 30; idx++) send_pixel(idx);
    out_ready = 1'b0;
    reset     = 1'b1;
    @(negedge clk);
    check("pre_reset_pending", out_valid, 1'b1);
    @(posedge clk); #1;
    reset     = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("midreset_out_valid", out_valid, 1'b0);
    check("midreset_discarded", exp_q.size(), 1);
    exp_q.delete();
    brow = 0;
    bcol = 0;
    @(posedge clk); #1;
    start_test();
    send_frame(100, 1'b0);
    drain();
    check("midreset_count", win_cnt, 36);
    if (seen.size() >= 1) check("midreset_first_window", seen[0], pack9(first_r));

    // Back-to-back frames
    start_test();
    send_frame(0, 1'b0);
    send_frame(200, 1'b0);
    drain();
    check("b2b_count", win_cnt, 72);
    check("b2b_frame_done_count", fd_cnt, 2);
    if (seen.size() >= 37) begin
      check("b2b_a_last_window", seen[35], pack9(last_a));
      check("b2b_b_first_window", seen[36], pack9(first_b));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
- Upstream stage of the conv PIM core.
- Takes a raster-order stream of 12-bit feature-map pixels and builds 3x3 sliding windows using two line buffers.
- Each valid window is presented as the 108-bit `operands` bus (9 x 12-bit) with a valid/ready handshake, so the core can consume one window per accepted beat.
- Windows use stride 1 and no padding. Each frame yields (IMG_W-2)*(IMG_H-2) windows.

Parameters:
- DATA_W, 12, pixel width (one operand lane).
- IMG_W, 8, frame width in pixels, >=3.
- IMG_H, 8, frame height in pixels, >=3.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  pixel beat valid.
- in_data  in  DATA_W  pixel value, raster order (row-major, col 0 first).
- in_ready  out  1  block can accept a pixel this cycle.
- out_valid  out  1  `operands` holds a complete window.
- out_ready  in  1  downstream consumes the window this cycle.
- operands  out  9*DATA_W  window; lane k=r*3+c at bits [12k+11:12k], r=0 oldest row, c=0 leftmost column.
- frame_done  out  1  asserted together with the final window of a frame, for as long as that window is held.

Behaviour:
- Reset values:
  - out_valid=0, operands=0, frame_done=0.
  - Column/row counters=0.
  - Window shift registers=0.
  - Line-buffer RAM is not cleared; stale contents are never emitted.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational); it is 1 right after reset.
  - A pixel is accepted when in_valid && in_ready.
  - Output register advances on accept; it holds (operands and frame_done stable) while out_valid && !out_ready.
- On accepting pixel p at (row, col):
  - The new column is {lb2[col], lb1[col], p}, i.e. rows r=0,1,2.
  - Window columns shift: c0<=c1, c1<=c2, c2<=new column.
  - Line buffers update: lb2[col]<=lb1[col], lb1[col]<=p.
  - col increments. At col=IMG_W-1 it wraps to 0 and row increments.
  - At (IMG_W-1, IMG_H-1) both counters wrap to 0, ready for the next frame with no idle cycle.
- Window emission:
  - If row>=2 && col>=2 for the accepted pixel, then on the next cycle out_valid=1 and operands = the updated window. Latency is 1 cycle from accept.
  - frame_done=1 iff that window ends at (IMG_W-1, IMG_H-1).
- If an accept does not produce a window and out_ready is high, out_valid falls to 0.
- Simultaneous consume and new window: the new window replaces the old one in the same edge. No bubble.
- A pixel that does not produce a window is still accepted only when in_ready=1. Backpressure stalls the whole stream; no pixel is dropped.
- Windows never straddle rows (col>=2 gate) or frames (row>=2 gate after wrap). Previous-frame data in the line buffers is unreachable.
- Reset mid-frame:
  - Takes effect at the next edge. Counters clear and any pending window is discarded (out_valid=0).
  - The next accepted pixel is treated as (0,0) of a new frame.
- Widths: no arithmetic on pixel data. Counters are $clog2(IMG_W) and $clog2(IMG_H) bits.

Decomposition:
- Package `conv_pkg`:
  - DATA_W=12, WIN_K=3, WIN_N=9, OPERANDS_W=108. These are shared with the core (`operands` width).
  - Lane-index helper: localparam offsets 12k.
- Sub-module `conv_line_buffer`:
  - One IMG_W x DATA_W row memory with combinational read at addr and write-on-accept.
  - Instantiated twice (lb1, lb2).
- Top level holds the counters, window registers and handshake.

Test Plan:
- Streaming frame: 8x8 frame, pixel = row*8+col, out_ready=1.
  - Exactly 36 windows.
  - First window 1 cycle after pixel 18 is accepted: lanes k0..k8 = 0,1,2,8,9,10,16,17,18.
  - Last window k0=45, k8=63 with frame_done=1. frame_done=0 on all other windows.
- Backpressure: out_ready=0 for 5 cycles after the first window appears.
  - operands stays at k8=18 and in_ready=0 for those cycles.
  - After release, the next window has k8=19. The window count is still 36.
- Sparse input: in_valid toggled 1,0,0,1 pattern.
  - Window contents are identical to the streaming case.
  - out_valid pulses only after accepts with col>=2 && row>=2.
- Reset mid-frame: assert reset after 30 accepts.
  - out_valid=0 next cycle.
  - A new frame with pixel = 100+row*8+col gives a first window with k0=100, k8=118.
- Back-to-back frames: frame A values 0..63, then frame B values 200+idx with no gap.
  - Frame B's first window is k0=200..k8=218, with no lane from frame A.
  - 72 windows total, with frame_done pulsed twice.
